gear_timer_unit: RTL and testbench

Synthesizable timing and speedometer stage placed directly downstream of the six‑speed gearbox FSM (`C_Velocidad`). It consumes the FSM's timer‑select code `et`, decel enable `etd` and current gear `va`. It produces the per‑gear acceleration‑complete pulses `t[4:0]` (T1..T5), the deceleration pulse `td` and the speedometer value `speed`, all of which are fed back to the FSM. It replaces the delay‑based timer models with one clocked block that shares the FSM clock.

---
 rtl/gear_timer_unit_if.sv | 13 +
 rtl/gear_timer_unit.sv | 118 +++++++++++
 tb/tb_gear_timer_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/gear_timer_unit_if.sv
// rtl/gear_timer_unit_if.sv - gearbox FSM <-> timer/speedometer signal bundle
interface gear_timer_unit_if;
  logic [2:0] et;
  logic       etd;
  logic [2:0] va;
  logic [4:0] t;
  logic       td;
  logic [3:0] speed;
  logic       busy;

  modport master (output et, etd, va, input t, td, speed, busy);
  modport slave  (input et, etd, va, output t, td, speed, busy);
endinterface

// File: rtl/gear_timer_unit.sv
// rtl/gear_timer_unit.sv - per-gear accel/decel timers and speedometer for the gearbox FSM
module gear_timer_unit #(
  parameter int TICK_DIV    = 10,
  parameter int DECEL_TICKS = 3
) (
  input logic              clk,
  input logic              rst,
  gear_timer_unit_if.slave bus
);
  // Selection codes: 1..5 are ACCEL(k) with k equal to the code.
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CRUISE = 3'd6;
  localparam logic [2:0] S_DECEL  = 3'd7;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (DECEL_TICKS > 0) ? $clog2(DECEL_TICKS + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(DECEL_TICKS);

  logic [2:0]    sel_q, sel_d, mode;
  logic [PW-1:0] pre_q, pre_d;
  logic [SW-1:0] step_q, step_d;
  logic [3:0]    speed_q, speed_d, limit;
  logic [4:0]    t_q, t_d;
  logic          td_q, td_d, busy_q, busy_d, tick;
  logic [2:0]    acc_idx;

  always_comb begin
    mode = S_IDLE;
    if (bus.etd)
      mode = S_DECEL;
    else if (bus.et >= 3'd1 && bus.et <= 3'd4)
      mode = bus.et;
    else if (bus.et == 3'd5)
      mode = (bus.va == 3'd6) ? S_CRUISE : 3'd5;
  end

  assign limit   = {1'b0, sel_q} + 4'd2;
  assign acc_idx = sel_q - 3'd1;
  assign tick    = (pre_q == PRE_LAST);

  always_comb begin
    sel_d   = sel_q;
    pre_d   = pre_q;
    step_d  = step_q;
    speed_d = speed_q;
    t_d     = '0;
    td_d    = 1'b0;
    if (mode != sel_q) begin
      // New selection drops whatever count was in flight, including a due pulse.
      sel_d   = mode;
      pre_d   = '0;
      step_d  = '0;
      speed_d = '0;
    end else if (sel_q == S_IDLE) begin
      pre_d   = '0;
      step_d  = '0;
      speed_d = '0;
    end else begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        case (sel_q)
          S_CRUISE: begin
            if (speed_q == 4'd0) begin
              speed_d = 4'd1;
              t_d[4]  = 1'b1;
            end else begin
              speed_d = 4'd0;
            end
          end
          S_DECEL: begin
            speed_d = 4'd0;
            if (step_q == STEP_LAST) begin
              step_d = '0;
            end else begin
              step_d = step_q + SW'(1);
              td_d   = (step_q + SW'(1) == STEP_LAST);
            end
          end
          default: begin
            if (speed_q < limit) begin
              speed_d = speed_q + 4'd1;
              t_d[acc_idx] = (speed_q + 4'd1 == limit);
            end else begin
              speed_d = 4'd0;
            end
          end
        endcase
      end
    end
    busy_d = (sel_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= S_IDLE;
      pre_q   <= '0;
      step_q  <= '0;
      speed_q <= '0;
      t_q     <= '0;
      td_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      pre_q   <= pre_d;
      step_q  <= step_d;
      speed_q <= speed_d;
      t_q     <= t_d;
      td_q    <= td_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.t     = t_q;
  assign bus.td    = td_q;
  assign bus.speed = speed_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_gear_timer_unit.sv
// tb/tb_gear_timer_unit.sv - three parameterisations of gear_timer_unit against a closed-form model
module tb_gear_timer_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] et_s = 3'd0;
  logic       etd_s = 1'b0;
  logic [2:0] va_s = 3'd1;
  int checks = 0;
  int errors = 0;
  int ecount = 0;
  int e0 = 0;
  int m_sel = 0;
  int m_n = 0;

  localparam int D  [3] = '{1, 2, 4};
  localparam int DT [3] = '{3, 3, 2};

  always #5 clk = ~clk;

  gear_timer_unit_if if0 ();
  gear_timer_unit_if if1 ();
  gear_timer_unit_if if2 ();

  assign if0.et = et_s;  assign if0.etd = etd_s;  assign if0.va = va_s;
  assign if1.et = et_s;  assign if1.etd = etd_s;  assign if1.va = va_s;
  assign if2.et = et_s;  assign if2.etd = etd_s;  assign if2.va = va_s;

  gear_timer_unit #(.TICK_DIV(1), .DECEL_TICKS(3)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  gear_timer_unit #(.TICK_DIV(2), .DECEL_TICKS(3)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  gear_timer_unit #(.TICK_DIV(4), .DECEL_TICKS(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic [10:0] act [3];
  assign act[0] = {if0.t, if0.td, if0.speed, if0.busy};
  assign act[1] = {if1.t, if1.td, if1.speed, if1.busy};
  assign act[2] = {if2.t, if2.td, if2.speed, if2.busy};

  // Mode codes: 0 none, 1..5 accel gear k, 6 cruise, 7 decel.
  function automatic int decode(logic [2:0] et, logic etd, logic [2:0] va);
    if (etd) return 7;
    if (et >= 1 && et <= 4) return int'(et);
    if (et == 5) return (va == 6) ? 6 : 5;
    return 0;
  endfunction

  // Outputs after the n-th edge following the edge that latched selection sel.
  function automatic logic [10:0] exp_out(int sel, int n, int d, int dt);
    logic [4:0] t;
    logic td;
    int spd, ticks, ph;
    bit on_tick;
    t = '0; td = 1'b0; spd = 0;
    ticks = n / d;
    on_tick = (n > 0) && (n % d == 0);
    if (sel == 0) return 11'd0;
    if (sel <= 5) begin
      ph = ticks % (sel + 3);
      spd = ph;
      if (on_tick && ph == sel + 2) t[sel-1] = 1'b1;
    end else if (sel == 6) begin
      ph = ticks % 2;
      spd = ph;
      if (on_tick && ph == 1) t[4] = 1'b1;
    end else begin
      ph = ticks % (dt + 1);
      if (on_tick && ph == dt) td = 1'b1;
    end
    return {t, td, 4'(spd), 1'b1};
  endfunction

  always @(posedge clk) ecount <= ecount + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_sel <= 0;
      m_n   <= 0;
    end else if (decode(et_s, etd_s, va_s) != m_sel) begin
      m_sel <= decode(et_s, etd_s, va_s);
      m_n   <= 0;
    end else begin
      m_n <= m_n + 1;
    end
  end

  always @(negedge clk) begin
    logic [10:0] e;
    for (int i = 0; i < 3; i++) begin
      e = exp_out(m_sel, m_n, D[i], DT[i]);
      checks++;
      if (act[i] !== e) begin
        errors++;
        $display("FAIL model_cmp inst%0d at %0t: got {t,td,speed,busy}=%h required %h",
                 i, $time, act[i], e);
      end
    end
  end

  task automatic chk(string name, int got, int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d required %0d", name, $time, got, req);
    end
  endtask

  task automatic set_in(logic [2:0] et, logic etd, logic [2:0] va);
    @(posedge clk);
    #2;
    et_s = et; etd_s = etd; va_s = va;
    e0 = ecount + 1;
  endtask

  task automatic wait_after(int n);
    while (ecount < e0 + n) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
  endtask

  initial begin
    int hold;
    #3;
    chk("reset_busy", int'(if2.busy), 0);
    chk("reset_speed", int'(if2.speed), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // ACCEL(1)
    set_in(3'd1, 1'b0, 3'd1);
    wait_after(3);  chk("a1_d1_t", int'(if0.t), 1);  chk("a1_d1_speed", int'(if0.speed), 3);
    wait_after(4);  chk("a1_speed4", int'(if2.speed), 1);
    wait_after(8);  chk("a1_speed8", int'(if2.speed), 2);
    wait_after(12); chk("a1_speed12", int'(if2.speed), 3); chk("a1_t12", int'(if2.t), 1);
    wait_after(13); chk("a1_t13", int'(if2.t), 0);
    wait_after(16); chk("a1_speed16", int'(if2.speed), 0);
    wait_after(28); chk("a1_t28", int'(if2.t), 1);

    // DECEL with priority over et
    set_in(3'd3, 1'b1, 3'd1);
    wait_after(3);  chk("dec_td3", int'(if0.td), 1); chk("dec_t3", int'(if0.t), 0);
    wait_after(4);  chk("dec_td4", int'(if0.td), 0);
    wait_after(7);  chk("dec_td7", int'(if0.td), 1); chk("dec_speed7", int'(if0.speed), 0);
    wait_after(11); chk("dec_td11", int'(if0.td), 1);

    // CRUISE, then va 6 -> 5 restarts the 5th-gear ramp
    set_in(3'd5, 1'b0, 3'd6);
    wait_after(2);  chk("cru_speed2", int'(if1.speed), 1); chk("cru_t2", int'(if1.t), 16);
    wait_after(4);  chk("cru_speed4", int'(if1.speed), 0); chk("cru_t4", int'(if1.t), 0);
    wait_after(6);  chk("cru_t6", int'(if1.t), 16);
    set_in(3'd5, 1'b0, 3'd5);
    wait_after(0);  chk("g5_speed0", int'(if1.speed), 0);
    wait_after(2);  chk("g5_speed2", int'(if1.speed), 1); chk("g5_t2", int'(if1.t), 0);
    wait_after(7);  chk("g5_d1_speed7", int'(if0.speed), 7); chk("g5_d1_t7", int'(if0.t), 16);

    // Abort: et 4 -> 2 sampled one edge before the T4 limit
    set_in(3'd4, 1'b0, 3'd3);
    wait_after(3);
    set_in(3'd2, 1'b0, 3'd3);
    wait_after(0);  chk("ab_speed0", int'(if0.speed), 0); chk("ab_t0", int'(if0.t), 0);
    wait_after(1);  chk("ab_t1", int'(if0.t), 0);
    wait_after(4);  chk("ab_t4", int'(if0.t), 2);

    // Reset during a td pulse, release with et=1 held
    set_in(3'd0, 1'b1, 3'd1);
    wait_after(3);  chk("rst_td_before", int'(if0.td), 1);
    #1 rst = 1'b1;
    #1 chk("rst_td_after", int'(if0.td), 0); chk("rst_busy0", int'(if0.busy), 0);
    et_s = 3'd1; etd_s = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    e0 = ecount + 1;
    wait_after(4);  chk("rr_speed4", int'(if2.speed), 1);
    wait_after(12); chk("rr_t12", int'(if2.t), 1);
    wait_after(16); chk("rr_speed16", int'(if2.speed), 0);
    wait_after(24); chk("rr_speed24", int'(if2.speed), 2);
    #1 rst = 1'b1;
    #1 chk("rst_ramp_speed", int'(if2.speed), 0); chk("rst_ramp_busy", int'(if2.busy), 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Randomized selections with occasional gear flips and resets
    for (int s = 0; s < 250; s++) begin
      @(posedge clk);
      #2;
      etd_s = ($urandom_range(0, 9) == 0);
      et_s  = 3'($urandom_range(0, 7));
      if (et_s == 3'd5 && $urandom_range(0, 1) == 1) va_s = 3'd6;
      else va_s = 3'($urandom_range(1, 6));
      hold = $urandom_range(1, 60);
      for (int c = 0; c < hold; c++) begin
        @(posedge clk);
        #2;
        if ($urandom_range(0, 29) == 0) va_s = (va_s == 3'd6) ? 3'd5 : 3'd6;
        rst = ($urandom_range(0, 199) == 0);
      end
      rst = 1'b0;
    end
    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
